load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Pipeline-side initiator for the data memory port in the MEM stage.
- Accepts a load/store request (mem_op_t) from the EX/MEM register.
- Aligned accesses pass straight through to data_memory in one cycle.
- Misaligned halfword/word accesses are split by an FSM into sequential byte accesses. The pipeline is stalled and the load result is reassembled before it is returned.

Parameters:
- ADDR_W, 32, width of request and memory addresses.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  request present; held stable by pipeline while stall=1
- req_op  in  mem_op_t  MEM_NOP/SB/SH/SW/LB/LH/LW/LBU/LHU
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- stall  out  1  pipeline must hold request and freeze upstream
- resp_valid  out  1  load/store complete this cycle
- resp_rdata  out  32  load result, extended per op; 0 for stores
- misaligned_trap  out  1  misaligned access trap (MISALIGN_TRAP_EN only)
- mem_wr_en  out  1  to data_memory wr_en
- mem_ctrl  out  mem_op_t  to data_memory mem_ctrl
- mem_addr  out  32  to data_memory addr
- mem_wdata  out  32  to data_memory data_in
- mem_rdata  in  32  from data_memory data_out (combinational read)

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: state=IDLE, idx=0, byte buffer=0, latched op/addr/wdata=0. stall=0, resp_valid=0, mem_wr_en=0, mem_ctrl=MEM_NOP.
- Misaligned definition:
  - LH, LHU, SH: addr[0]=1 → N=2.
  - LW, SW: addr[1:0]!=0 → N=4.
  - Byte ops and MEM_NOP are never misaligned.
- States: IDLE, SPLIT, DONE.
- IDLE with an aligned request, or req_valid=0:
  - Combinational pass-through: mem_ctrl=req_op, mem_addr=req_addr, mem_wdata=req_wdata.
  - mem_wr_en = req_valid and op is a store.
  - resp_valid = req_valid and op!=MEM_NOP. resp_rdata = mem_rdata for loads, 0 for stores.
  - stall=0. Latency 0: the store commits at the next clk edge.
- IDLE with a misaligned request:
  - stall=1, mem_ctrl=MEM_NOP, mem_wr_en=0, resp_valid=0.
  - Latch op, addr, wdata and N. Set idx=0. Next state SPLIT.
- SPLIT:
  - stall=1. mem_addr = latched addr + idx, wrapping modulo 2^32.
  - Loads: mem_ctrl=MEM_LBU, mem_wr_en=0. At the clock edge, capture mem_rdata[7:0] into buffer byte idx.
  - Stores: mem_ctrl=MEM_SB, mem_wr_en=1, mem_wdata = {24'b0, wdata[8*idx+:8]}.
  - idx increments each cycle. When idx=N-1, next state is DONE.
- DONE:
  - stall=0, resp_valid=1, mem_ctrl=MEM_NOP, mem_wr_en=0.
  - resp_rdata:
    - LH: sign-extend buffer[15:0].
    - LHU: zero-extend buffer[15:0].
    - LW: buffer[31:0].
    - Stores: 0.
  - The request present this cycle is the one already served and is ignored. Next state IDLE unconditionally.
- Total misaligned latency: N+2 cycles, with stall high for N+1 cycles.
- Byte order is little-endian: byte idx maps to bits [8*idx+7:8*idx].
- Reset during SPLIT: return to IDLE immediately; no response is issued. Bytes already stored stay in memory.
- Changes to req_* while stall=1 are ignored: latched values are used.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - Misaligned requests are not split.
  - In IDLE, misaligned_trap=req_valid combinationally for that cycle.
  - mem_wr_en=0, mem_ctrl=MEM_NOP, resp_valid=0, stall=0, and the FSM stays IDLE.
  - The SPLIT/DONE logic and byte buffer are not built.
- Undefined: misaligned_trap is tied to 0 and splitting operates as specified above.

Test Plan:
- Aligned SW 0x89ABCDEF @100, then LW @100 → mem_wr_en pulse for one cycle, no stall; LW resp_valid=1 same cycle with resp_rdata=0x89ABCDEF.
- Misaligned SW 0x11223344 @201 → stall high 5 cycles; 4 MEM_SB writes to 201..204 with bytes 44,33,22,11; resp_valid=1 in cycle 6. Then LBU @203 → 0x00000022.
- With 0x89ABCDEF @100: misaligned LH @101 → 0xFFFFABCD after 4 cycles; LHU @101 → 0x0000ABCD; misaligned LW @102 with 0x00000055 @104 → 0x005589AB.
- Back-to-back: misaligned LW immediately followed by aligned LW → the second request is served exactly once, in the cycle after DONE; no duplicate memory write or response.
- rst asserted during the 2nd SPLIT cycle of misaligned SW 0xAABBCCDD @301 → outputs return to reset values asynchronously; only byte 301=0xDD is written; no resp_valid.
- MISALIGN_TRAP_EN defined: LW @102 → misaligned_trap=1 for one cycle, stall=0, mem_wr_en=0; aligned LW @100 still returns correct data.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage initiator for data_memory; splits misaligned half/word accesses into byte accesses
// Optional build macro: MISALIGN_TRAP_EN (misaligned requests raise misaligned_trap instead of being split)
// Ports:
//   clk, rst                     clock and asynchronous active-high reset
//   req_valid/op/addr/wdata      request from the EX/MEM register (held while stall=1)
//   stall                        freeze upstream while a split access is in flight
//   resp_valid, resp_rdata       completion and load result (0 for stores)
//   misaligned_trap              misaligned request seen (trap build only, else 0)
//   mem_wr_en/ctrl/addr/wdata    drive data_memory
//   mem_rdata                    combinational read data from data_memory
package load_store_unit_pkg;
    typedef enum logic [3:0] {
        MEM_NOP, MEM_SB, MEM_SH, MEM_SW, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU
    } mem_op_t;
endpackage

module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  mem_op_t           req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              misaligned_trap,
    output logic              mem_wr_en,
    output mem_op_t           mem_ctrl,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);
    function automatic logic is_store(input mem_op_t op);
        return op inside {MEM_SB, MEM_SH, MEM_SW};
    endfunction

    function automatic logic is_load(input mem_op_t op);
        return op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
    endfunction

    logic is_word, is_mis;
    assign is_word = req_op inside {MEM_LW, MEM_SW};
    assign is_mis  = ((req_op inside {MEM_LH, MEM_LHU, MEM_SH}) && req_addr[0]) ||
                     (is_word && req_addr[1:0] != 2'b00);

`ifdef MISALIGN_TRAP_EN
    assign misaligned_trap = !rst && req_valid && is_mis;

    always_comb begin
        stall      = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        mem_wr_en  = 1'b0;
        mem_ctrl   = MEM_NOP;
        mem_addr   = 32'(req_addr);
        mem_wdata  = req_wdata;
        if (!rst && !(req_valid && is_mis)) begin
            mem_ctrl   = req_op;
            mem_wr_en  = req_valid && is_store(req_op);
            resp_valid = req_valid && req_op != MEM_NOP;
            resp_rdata = is_load(req_op) ? mem_rdata : '0;
        end
    end
`else
    typedef enum logic [1:0] {IDLE, SPLIT, DONE} state_t;

    state_t            state;
    mem_op_t           op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q, buf_q;
    logic [1:0]        idx, last_q;
    logic [31:0]       done_rdata;

    assign misaligned_trap = 1'b0;

    assign done_rdata = op_q == MEM_LH  ? {{16{buf_q[15]}}, buf_q[15:0]} :
                        op_q == MEM_LHU ? {16'b0, buf_q[15:0]} :
                        op_q == MEM_LW  ? buf_q : '0;

    always_comb begin
        stall      = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        mem_wr_en  = 1'b0;
        mem_ctrl   = MEM_NOP;
        mem_addr   = 32'(req_addr);
        mem_wdata  = req_wdata;
        if (rst) begin
            stall = 1'b0;
        end else if (state == SPLIT) begin
            stall     = 1'b1;
            mem_addr  = 32'(addr_q + ADDR_W'(idx));
            mem_ctrl  = is_store(op_q) ? MEM_SB : MEM_LBU;
            mem_wr_en = is_store(op_q);
            mem_wdata = {24'b0, wdata_q[{idx, 3'b000} +: 8]};
        end else if (state == DONE) begin
            resp_valid = 1'b1;
            resp_rdata = done_rdata;
        end else if (req_valid && is_mis) begin
            stall = 1'b1;
        end else begin
            mem_ctrl   = req_op;
            mem_wr_en  = req_valid && is_store(req_op);
            resp_valid = req_valid && req_op != MEM_NOP;
            resp_rdata = is_load(req_op) ? mem_rdata : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            op_q    <= MEM_NOP;
            addr_q  <= '0;
            wdata_q <= '0;
            buf_q   <= '0;
            idx     <= '0;
            last_q  <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid && is_mis) begin
                    op_q    <= req_op;
                    addr_q  <= req_addr;
                    wdata_q <= req_wdata;
                    last_q  <= is_word ? 2'd3 : 2'd1;
                    idx     <= '0;
                    state   <= SPLIT;
                end
                SPLIT: begin
                    if (!is_store(op_q)) buf_q[{idx, 3'b000} +: 8] <= mem_rdata[7:0];
                    idx <= idx + 2'd1;
                    if (idx == last_q) state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`endif
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized self-checking bench with byte-level memory and reference model
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid;
    mem_op_t     req_op;
    logic [31:0] req_addr, req_wdata;
    logic        stall, resp_valid, misaligned_trap, mem_wr_en;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
    mem_op_t     mem_ctrl;

    load_store_unit #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .misaligned_trap(misaligned_trap), .mem_wr_en(mem_wr_en),
        .mem_ctrl(mem_ctrl), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int wr_cnt = 0, resp_cnt = 0, exp_wr = 0, exp_resp = 0;
    logic [7:0] mem [0:1023];
    logic [7:0] ref_mem [0:1023];

    // data_memory stand-in: combinational read with per-op extension, write on clk
    logic [9:0] a;
    logic [7:0] b0, b1, b2, b3;
    always_comb begin
        a = mem_addr[9:0];
        b0 = mem[a];
        b1 = mem[a + 10'd1];
        b2 = mem[a + 10'd2];
        b3 = mem[a + 10'd3];
        case (mem_ctrl)
            MEM_LB:  mem_rdata = {{24{b0[7]}}, b0};
            MEM_LBU: mem_rdata = {24'b0, b0};
            MEM_LH:  mem_rdata = {{16{b1[7]}}, b1, b0};
            MEM_LHU: mem_rdata = {16'b0, b1, b0};
            MEM_LW:  mem_rdata = {b3, b2, b1, b0};
            default: mem_rdata = '0;
        endcase
    end

    always @(posedge clk) begin
        if (mem_wr_en) begin
            case (mem_ctrl)
                MEM_SB: mem[a] <= mem_wdata[7:0];
                MEM_SH: begin
                    mem[a] <= mem_wdata[7:0];
                    mem[a + 10'd1] <= mem_wdata[15:8];
                end
                MEM_SW: begin
                    mem[a] <= mem_wdata[7:0];
                    mem[a + 10'd1] <= mem_wdata[15:8];
                    mem[a + 10'd2] <= mem_wdata[23:16];
                    mem[a + 10'd3] <= mem_wdata[31:24];
                end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_wr_en) wr_cnt <= wr_cnt + 1;
            if (resp_valid) resp_cnt <= resp_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic int op_size(input mem_op_t op);
        if (op inside {MEM_SB, MEM_LB, MEM_LBU}) return 1;
        if (op inside {MEM_SH, MEM_LH, MEM_LHU}) return 2;
        if (op inside {MEM_SW, MEM_LW}) return 4;
        return 0;
    endfunction

    // Expected load value built from little-endian bytes of the reference memory
    function automatic logic [31:0] ref_load(input mem_op_t op, input logic [31:0] addr);
        logic [31:0] v = '0;
        for (int i = 0; i < op_size(op); i++) v[8*i +: 8] = ref_mem[addr[9:0] + 10'(i)];
        if (op == MEM_LB) v = {{24{v[7]}}, v[7:0]};
        if (op == MEM_LH) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    task automatic idle(input int n);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_req(input mem_op_t op, input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd);
        int sz = op_size(op);
        bit mis = sz > 1 && (addr % sz) != 0;
        bit st = op inside {MEM_SB, MEM_SH, MEM_SW};
        bit ld = op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
        logic [31:0] exp = ld ? ref_load(op, addr) : 32'h0;
        int stalls = 0;
        bit got = 0;
        rd = '0;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_op = op;
        req_addr = addr;
        req_wdata = wd;
        if (op == MEM_NOP) begin
            @(negedge clk);
            chk("nop_resp", resp_valid, 0);
            chk("nop_wr", mem_wr_en, 0);
            return;
        end
`ifdef MISALIGN_TRAP_EN
        if (mis) begin
            @(negedge clk);
            chk("trap", misaligned_trap, 1);
            chk("trap_stall", stall, 0);
            chk("trap_wr", mem_wr_en, 0);
            chk("trap_resp", resp_valid, 0);
            return;
        end
`endif
        for (int c = 0; c < 12 && !got; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                got = 1;
                rd = resp_rdata;
                chk("trap_idle", misaligned_trap, 0);
            end else begin
                if (stall) stalls++;
                @(posedge clk);
                #1;
                req_addr = $urandom;
                req_wdata = $urandom;
            end
        end
        chk("resp_seen", got, 1);
        chk("stall_cycles", stalls, mis ? sz + 1 : 0);
        chk(ld ? "load_data" : "store_rdata", rd, exp);
        if (st) begin
            for (int i = 0; i < sz; i++) ref_mem[addr[9:0] + 10'(i)] = wd[8*i +: 8];
            exp_wr += mis ? sz : 1;
        end
        exp_resp++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] r;
        int r0, e0, bad;
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        req_valid = 1'b0;
        req_op = MEM_NOP;
        req_addr = '0;
        req_wdata = '0;
        #12;
        chk("rst_stall", stall, 0);
        chk("rst_resp", resp_valid, 0);
        chk("rst_wr", mem_wr_en, 0);
        chk("rst_ctrl", mem_ctrl, MEM_NOP);
        chk("rst_trap", misaligned_trap, 0);
        @(negedge clk);
        rst = 1'b0;

        do_req(MEM_SW, 100, 32'h89ABCDEF, r);
        do_req(MEM_LW, 100, 0, r);
        chk("lw100", r, 32'h89ABCDEF);
        do_req(MEM_SW, 201, 32'h11223344, r);
        do_req(MEM_LBU, 203, 0, r);
`ifndef MISALIGN_TRAP_EN
        chk("sw201_b0", mem[201], 8'h44);
        chk("sw201_b3", mem[204], 8'h11);
        chk("lbu203", r, 32'h22);
`endif
        do_req(MEM_LH, 101, 0, r);
`ifndef MISALIGN_TRAP_EN
        chk("lh101", r, 32'hFFFFABCD);
`endif
        do_req(MEM_LHU, 101, 0, r);
`ifndef MISALIGN_TRAP_EN
        chk("lhu101", r, 32'h0000ABCD);
`endif
        do_req(MEM_SW, 104, 32'h00000055, r);
        do_req(MEM_LW, 102, 0, r);
`ifndef MISALIGN_TRAP_EN
        chk("lw102", r, 32'h005589AB);
`endif
        idle(1);
        r0 = resp_cnt;
        e0 = exp_resp;
        do_req(MEM_LW, 102, 0, r);
        do_req(MEM_LW, 100, 0, r);
        chk("b2b_lw100", r, 32'h89ABCDEF);
        idle(2);
        chk("b2b_resp_cnt", resp_cnt - r0, exp_resp - e0);

`ifndef MISALIGN_TRAP_EN
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_op = MEM_SW;
        req_addr = 301;
        req_wdata = 32'hAABBCCDD;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        req_valid = 1'b0;
        #1;
        chk("arst_stall", stall, 0);
        chk("arst_resp", resp_valid, 0);
        chk("arst_wr", mem_wr_en, 0);
        chk("arst_ctrl", mem_ctrl, MEM_NOP);
        #2;
        rst = 1'b0;
        ref_mem[301] = 8'hDD;
        exp_wr += 1;
        idle(2);
        chk("arst_b301", mem[301], 8'hDD);
        chk("arst_b302", mem[302], ref_mem[302]);
`endif

        repeat (150) begin
            do_req(mem_op_t'($urandom_range(0, 8)), $urandom_range(0, 1015), $urandom, r);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 2));
        end
        idle(3);
        chk("wr_count", wr_cnt, exp_wr);
        chk("resp_count", resp_cnt, exp_resp);
        bad = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
        chk("mem_image", bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
